// File: rtl/attn_row_scheduler.sv
// Attention row scheduler: walks Q rows x K/V rows into the dot-product stage with a row credit limit.
// Optional stall counter port/logic when SCHED_PERF_CNT_EN is defined.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif

module attn_row_scheduler #(
    parameter int Q_ROWS_MAX = 64,
    parameter int SEQ_LEN    = `MAX_SEQ_LENGTH,
    parameter int MAX_OUT    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [$clog2(Q_ROWS_MAX+1)-1:0] q_len,
    input  logic [$clog2(SEQ_LEN+1)-1:0]    k_len,
    input  logic                            abort,
    output logic                            req_vld,
    input  logic                            req_rdy,
    output logic [$clog2(Q_ROWS_MAX)-1:0]   req_q_idx,
    output logic [$clog2(SEQ_LEN)-1:0]      req_k_idx,
    output logic                            req_first,
    output logic                            req_last,
    input  logic                            row_retire,
    output logic                            busy,
    output logic                            done,
    output logic                            err
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                     stall_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for start
    // ISSUE  | issuing (q,k) requests, credit-limited at row boundaries
    // DRAIN  | all requests issued, waiting for outstanding rows to retire
    // DONE   | one-cycle completion pulse
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    localparam int QLW = $clog2(Q_ROWS_MAX + 1);
    localparam int QIW = $clog2(Q_ROWS_MAX);
    localparam int KLW = $clog2(SEQ_LEN + 1);
    localparam int KIW = $clog2(SEQ_LEN);
    localparam int OW  = $clog2(MAX_OUT + 1);

    localparam logic [QLW-1:0] Q_ONE    = QLW'(1);
    localparam logic [KLW-1:0] K_ONE    = KLW'(1);
    localparam logic [OW-1:0]  O_ONE    = OW'(1);
    localparam logic [OW-1:0]  OUT_FULL = OW'(MAX_OUT);

    state_t         state_q, state_d;
    logic [QLW-1:0] q_len_q, q_len_d;
    logic [KLW-1:0] k_len_q, k_len_d;
    logic [QLW-1:0] q_idx_q, q_idx_d;
    logic [KLW-1:0] k_idx_q, k_idx_d;
    logic [OW-1:0]  out_q, out_d;
    logic           req_vld_q, req_vld_d;
    logic           req_first_q, req_first_d;
    logic           req_last_q, req_last_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           xfer, row_xfer, retire_ok;

    always_comb begin
        xfer      = req_vld_q && req_rdy;
        row_xfer  = xfer && req_last_q;
        retire_ok = row_retire && (out_q != '0);

        state_d = state_q;
        q_len_d = q_len_q;
        k_len_d = k_len_q;
        q_idx_d = q_idx_q;
        k_idx_d = k_idx_q;
        err_d   = err_q || (row_retire && (out_q == '0));

        out_d = out_q;
        if (row_xfer && !retire_ok) begin
            out_d = out_q + O_ONE;
        end else if (!row_xfer && retire_ok) begin
            out_d = out_q - O_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((q_len != '0) && (k_len != '0)) begin
                        q_len_d = q_len;
                        k_len_d = k_len;
                        q_idx_d = '0;
                        k_idx_d = '0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (xfer) begin
                    if (req_last_q) begin
                        k_idx_d = '0;
                        q_idx_d = q_idx_q + Q_ONE;
                        if (q_idx_q == (q_len_q - Q_ONE)) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        k_idx_d = k_idx_q + K_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (out_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            q_idx_d = '0;
            k_idx_d = '0;
            out_d   = '0;
        end

        // Outputs are registered, so they are derived from the next-cycle values.
        req_vld_d   = (state_d == S_ISSUE) && !((k_idx_d == '0) && (out_d == OUT_FULL));
        req_first_d = (state_d == S_ISSUE) && (k_idx_d == '0);
        req_last_d  = (state_d == S_ISSUE) && (k_idx_d == (k_len_d - K_ONE));
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            q_len_q     <= '0;
            k_len_q     <= '0;
            q_idx_q     <= '0;
            k_idx_q     <= '0;
            out_q       <= '0;
            req_vld_q   <= 1'b0;
            req_first_q <= 1'b0;
            req_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_len_q     <= q_len_d;
            k_len_q     <= k_len_d;
            q_idx_q     <= q_idx_d;
            k_idx_q     <= k_idx_d;
            out_q       <= out_d;
            req_vld_q   <= req_vld_d;
            req_first_q <= req_first_d;
            req_last_q  <= req_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign req_vld   = req_vld_q;
    assign req_q_idx = q_idx_q[QIW-1:0];
    assign req_k_idx = k_idx_q[KIW-1:0];
    assign req_first = req_first_q;
    assign req_last  = req_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && start && !abort) begin
            stall_cnt_d = '0;
        end else if ((state_q == S_ISSUE) && (!req_vld_q || !req_rdy) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_attn_row_scheduler.sv
// Self-checking bench for attn_row_scheduler: directed steps plus randomized jobs
// checked against a queue-based model of the expected (q,k) request stream and row credits.
module tb_attn_row_scheduler;

    localparam int MAX_OUT_TB = 2;
    localparam int JOB_BOUND  = 3000;

    logic       clk;
    logic       rst;
    logic       start;
    logic [6:0] q_len;
    logic [6:0] k_len;
    logic       abort;
    logic       req_vld;
    logic       req_rdy;
    logic [5:0] req_q_idx;
    logic [5:0] req_k_idx;
    logic       req_first;
    logic       req_last;
    logic       row_retire;
    logic       busy;
    logic       done;
    logic       err;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks;
    int errors;
    int xfer_cnt;
    int done_seen;
    int last_q;
    int last_k;

    attn_row_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .q_len      (q_len),
        .k_len      (k_len),
        .abort      (abort),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_q_idx  (req_q_idx),
        .req_k_idx  (req_k_idx),
        .req_first  (req_first),
        .req_last   (req_last),
        .row_retire (row_retire),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef SCHED_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Observe this cycle's outputs, drive rdy/retire for it, then advance one clock.
    task automatic tick(input logic rdy_i, input logic ret_i);
        req_rdy    = rdy_i;
        row_retire = ret_i;
        if (req_vld && rdy_i) begin
            xfer_cnt++;
            last_q = int'(req_q_idx);
            last_k = int'(req_k_idx);
        end
        if (done) done_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vld"},   32'(req_vld),   32'd0);
        chk({tag, "_q"},     32'(req_q_idx), 32'd0);
        chk({tag, "_k"},     32'(req_k_idx), 32'd0);
        chk({tag, "_first"}, 32'(req_first), 32'd0);
        chk({tag, "_last"},  32'(req_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_err"},   32'(err),       32'd0);
    endtask

    // rdy_pct < 0 selects an alternating 1,0,1,0 ready pattern.
    task automatic run_job(input int qn, input int kn, input int rdy_pct, input int lat);
        int   eq[$];
        int   ek[$];
        int   due[$];
        int   cyc;
        int   model_out;
        int   done_cnt;
        logic prev_hold;
        logic [5:0] pq, pk;
        logic pf, pl;
        logic rdy_i, ret_i;
        for (int r = 0; r < qn; r++) begin
            for (int c = 0; c < kn; c++) begin
                eq.push_back(r);
                ek.push_back(c);
            end
        end
        q_len = 7'(qn);
        k_len = 7'(kn);
        start = 1'b1;
        req_rdy = 1'b0;
        row_retire = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        model_out = 0;
        done_cnt = 0;
        prev_hold = 1'b0;
        pq = '0; pk = '0; pf = 1'b0; pl = 1'b0;
        while (cyc < JOB_BOUND && !(done_cnt > 0 && eq.size() == 0 && due.size() == 0)) begin
            if (prev_hold) begin
                chk("hold_vld",   32'(req_vld),   32'd1);
                chk("hold_q",     32'(req_q_idx), 32'(pq));
                chk("hold_k",     32'(req_k_idx), 32'(pk));
                chk("hold_first", 32'(req_first), 32'(pf));
                chk("hold_last",  32'(req_last),  32'(pl));
            end
            chk("no_extra_vld", 32'(req_vld && (eq.size() == 0)), 32'd0);
            if (eq.size() != 0) begin
                chk("vld_rule", 32'(req_vld), 32'(!((model_out == MAX_OUT_TB) && (ek[0] == 0))));
            end
            if (rdy_pct < 0) rdy_i = (cyc % 2 == 0);
            else rdy_i = (int'($urandom_range(99)) < rdy_pct);
            ret_i = (due.size() != 0) && (due[0] <= cyc);
            if (ret_i) void'(due.pop_front());
            req_rdy    = rdy_i;
            row_retire = ret_i;
            if (req_vld && rdy_i && eq.size() != 0) begin
                chk("xfer_q",     32'(req_q_idx), 32'(eq[0]));
                chk("xfer_k",     32'(req_k_idx), 32'(ek[0]));
                chk("xfer_first", 32'(req_first), 32'(ek[0] == 0));
                chk("xfer_last",  32'(req_last),  32'(ek[0] == kn - 1));
                if (ek[0] == kn - 1) begin
                    model_out++;
                    due.push_back(cyc + 1 + lat);
                end
                void'(eq.pop_front());
                void'(ek.pop_front());
            end
            if (ret_i) model_out--;
            if (done) begin
                done_cnt++;
                chk("done_early", 32'(eq.size() + due.size()), 32'd0);
            end
            prev_hold = req_vld && !rdy_i;
            pq = req_q_idx; pk = req_k_idx; pf = req_first; pl = req_last;
            @(posedge clk);
            #1;
            cyc++;
        end
        req_rdy = 1'b0;
        row_retire = 1'b0;
        chk("job_timeout", 32'(cyc < JOB_BOUND), 32'd1);
        chk("job_done_once", 32'(done_cnt), 32'd1);
        chk("job_done_clear", 32'(done), 32'd0);
        chk("job_idle", 32'(busy), 32'd0);
        chk("job_vld_idle", 32'(req_vld), 32'd0);
        chk("job_no_err", 32'(err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        checks = 0; errors = 0; xfer_cnt = 0; done_seen = 0; last_q = 0; last_k = 0;
        rst = 1'b1; start = 1'b1; abort = 1'b0; req_rdy = 1'b1; row_retire = 1'b1;
        q_len = 7'd2; k_len = 7'd2;

        // Reset dominates start/retire.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0; start = 1'b0; row_retire = 1'b0; req_rdy = 1'b0;
        tick(0, 0);
        chk_reset_outputs("post_reset");

        run_job(2, 3, 100, 1);
        run_job(1, 4, -1, 0);
        run_job(3, 1, 100, 0);
        for (int j = 0; j < 8; j++) begin
            run_job(int'($urandom_range(5, 1)), int'($urandom_range(6, 1)),
                    int'($urandom_range(100, 30)), int'($urandom_range(6, 0)));
        end

        // Credit limit with single-K rows and no retires.
        xfer_cnt = 0; done_seen = 0;
        q_len = 7'd3; k_len = 7'd1; start = 1'b1;
        tick(1, 0);
        start = 1'b0;
        repeat (6) tick(1, 0);
        chk("cred_xfers", 32'(xfer_cnt), 32'd2);
        chk("cred_stall_vld", 32'(req_vld), 32'd0);
        chk("cred_busy", 32'(busy), 32'd1);
        tick(1, 1);
        repeat (4) tick(1, 0);
        chk("cred_third_xfer", 32'(xfer_cnt), 32'd3);
        chk("cred_third_q", 32'(last_q), 32'd2);
        chk("cred_drain_vld", 32'(req_vld), 32'd0);
        chk("cred_no_done", 32'(done_seen), 32'd0);
        tick(0, 1);
        tick(0, 1);
        repeat (4) tick(0, 0);
        chk("cred_done", 32'(done_seen), 32'd1);
        chk("cred_idle", 32'(busy), 32'd0);
        chk("cred_err", 32'(err), 32'd0);

        // Abort mid-row at (1,2).
        done_seen = 0;
        q_len = 7'd2; k_len = 7'd3; start = 1'b1;
        tick(0, 0);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (req_vld && req_q_idx == 6'd1 && req_k_idx == 6'd2) found = 1'b1;
            else tick(1, 0);
        end
        chk("abort_reach", 32'(found), 32'd1);
        abort = 1'b1;
        tick(0, 0);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_vld", 32'(req_vld), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (3) tick(0, 0);
        chk("abort_no_done", 32'(done_seen), 32'd0);
        q_len = 7'd1; k_len = 7'd1; start = 1'b1; abort = 1'b1;
        tick(0, 0);
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", 32'(busy), 32'd0);
        run_job(2, 3, 100, 1);

        // Zero-length job, then retire in IDLE sets sticky err.
        q_len = 7'd0; k_len = 7'd5; start = 1'b1;
        tick(0, 0);
        start = 1'b0;
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_vld", 32'(req_vld), 32'd0);
        tick(0, 0);
        chk("zero_done_clr", 32'(done), 32'd0);
        chk("zero_idle", 32'(busy), 32'd0);
        q_len = 7'd3; k_len = 7'd0; start = 1'b1;
        tick(0, 0);
        start = 1'b0;
        chk("zero_k_done", 32'(done), 32'd1);
        tick(0, 1);
        chk("err_set", 32'(err), 32'd1);
        repeat (5) tick(0, 0);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset while draining, with start asserted.
        q_len = 7'd1; k_len = 7'd1; start = 1'b1;
        tick(1, 0);
        start = 1'b0;
        tick(1, 0);
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_vld", 32'(req_vld), 32'd0);
        rst = 1'b1; start = 1'b1;
        tick(0, 1);
        chk_reset_outputs("rst_drain");
        rst = 1'b0; start = 1'b0;
        tick(0, 0);
        chk("rst_drain_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/attn_row_scheduler.md
ATTN_ROW_SCHEDULER -- requirements
Module: attn_row_scheduler

Interface
REQ-001 Parameter: Q_ROWS_MAX, default 64, max Q rows per job.
REQ-002 Parameter: SEQ_LEN, default `MAX_SEQ_LENGTH (64), max K/V rows per Q row.
REQ-003 Parameter: MAX_OUT, default 2, max Q rows issued but not yet retired.
REQ-004 Port: clk  in  1  single clock, all logic on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  job start pulse, honoured only in IDLE.
REQ-007 Port: q_len  in  $clog2(Q_ROWS_MAX+1)  Q rows in job, sampled on accepted start.
REQ-008 Port: k_len  in  $clog2(SEQ_LEN+1)  K/V rows per Q row, sampled on accepted start.
REQ-009 Port: abort  in  1  cancel job, return to IDLE.
REQ-010 Port: req_vld  out  1  issue request valid to dot-product stage.
REQ-011 Port: req_rdy  in  1  dot-product stage ready (its rdy_out).
REQ-012 Port: req_q_idx  out  $clog2(Q_ROWS_MAX)  Q row index of request.
REQ-013 Port: req_k_idx  out  $clog2(SEQ_LEN)  K/V row index of request.
REQ-014 Port: req_first / req_last  out  1 each  request is first / last K of its Q row.
REQ-015 Port: row_retire  in  1  one Q row fully consumed downstream.
REQ-016 Port: busy  out  1  state != IDLE.
REQ-017 Port: done  out  1  one-cycle pulse, job complete.
REQ-018 Port: err  out  1  sticky, retire with zero outstanding rows.

Function
REQ-019 States IDLE, ISSUE, DRAIN, DONE; encoding free.
REQ-020 IDLE: start=1 with q_len!=0 and k_len!=0 latches lengths, clears indices, -> ISSUE next cycle.
REQ-021 IDLE: start=1 with q_len==0 or k_len==0 -> DONE next cycle (done pulses, no requests); start while busy ignored.
REQ-022 ISSUE: req_vld=1 unless stalled; req_first=(k_idx==0); req_last=(k_idx==k_len_r-1).
REQ-023 Stall: req_vld=0 when k_idx==0 and outstanding==MAX_OUT; no mid-row stall.
REQ-024 Transfer = req_vld && req_rdy; on transfer k_idx++; on transfer with req_last, k_idx<=0, q_idx++, outstanding++.
REQ-025 req_q_idx, req_k_idx, req_first, req_last held stable while req_vld && !req_rdy.
REQ-026 Transfer of last K of last Q row -> DRAIN next cycle; req_vld=0 in DRAIN.
REQ-027 row_retire with outstanding>0 decrements outstanding; simultaneous row-issue and retire leaves it unchanged.
REQ-028 row_retire with outstanding==0: no change, err<=1 (cleared only by rst).
REQ-029 DRAIN: outstanding==0 -> DONE; DONE: done=1 for exactly that cycle, -> IDLE next cycle.
REQ-030 abort=1 in any state: -> IDLE next cycle, indices/outstanding cleared, no done pulse; abort beats start same cycle.
REQ-031 Retire pulses arriving in IDLE after abort set err.
REQ-032 Full pass throughput: one request per cycle with req_rdy=1 and no credit stall.

Reset
REQ-033 rst: state=IDLE, req_vld=0, req_q_idx=0, req_k_idx=0, req_first=0, req_last=0, busy=0, done=0, err=0, outstanding=0, latched lengths=0.
REQ-034 rst has priority over start, abort, row_retire in the same cycle.

Configuration
REQ-035 Macro SCHED_PERF_CNT_EN defined: adds output stall_cnt (32 bits), counting ISSUE cycles with req_vld=0 or req_rdy=0, cleared on rst and accepted start, saturating.
REQ-036 SCHED_PERF_CNT_EN undefined: no stall_cnt port or counter logic; all other behaviour identical.

Verification
REQ-037 q_len=2, k_len=3, req_rdy=1, retire 2 cycles after each req_last -> (q,k) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), first/last correct, done once.
REQ-038 q_len=3, k_len=1, MAX_OUT=2, no retire -> 2 transfers then req_vld=0; one retire -> third issued; two retires -> done.
REQ-039 req_rdy toggled 1010 during k_len=4 -> indices stable while stalled, no skipped or repeated index.
REQ-040 start with q_len=0 -> done pulse 1 cycle later, req_vld never 1; row_retire in IDLE -> err=1 held until rst.
REQ-041 abort during ISSUE at (1,2) -> IDLE next cycle, busy=0, no done; new start restarts at (0,0).
REQ-042 rst asserted mid-DRAIN with start=1 -> all outputs at reset values next cycle, state IDLE.
